// File: rtl/cbfp0_seq_ctrl_if.sv
// rtl/cbfp0_seq_ctrl_if.sv - Beat-valid input and sequencing outputs of the CBFP stage-0 sequencer
interface cbfp0_seq_ctrl_if #(
   parameter int ADDR_W = 5
);
   logic              i_din_valid;
   logic              o_mag_en;
   logic              o_min_clr;
   logic              o_wr_en;
   logic              o_wr_bank;
   logic [ADDR_W-1:0] o_wr_addr;
   logic              o_shift_load;
   logic              o_rd_en;
   logic              o_rd_bank;
   logic [ADDR_W-1:0] o_rd_addr;
   logic              o_dout_valid;
   logic [3:0]        o_blk_idx;
   logic              o_frame_done;
   logic              o_ovf;

   modport master (
      output i_din_valid,
      input  o_mag_en, o_min_clr, o_wr_en, o_wr_bank, o_wr_addr, o_shift_load,
      input  o_rd_en, o_rd_bank, o_rd_addr, o_dout_valid, o_blk_idx, o_frame_done, o_ovf
   );

   modport slave (
      input  i_din_valid,
      output o_mag_en, o_min_clr, o_wr_en, o_wr_bank, o_wr_addr, o_shift_load,
      output o_rd_en, o_rd_bank, o_rd_addr, o_dout_valid, o_blk_idx, o_frame_done, o_ovf
   );
endinterface

// File: rtl/cbfp0_seq_ctrl.sv
// rtl/cbfp0_seq_ctrl.sv - CBFP stage-0 sequencer: ping-pong block write, min-shift wait, block read
module cbfp0_seq_ctrl #(
   parameter int BLK_LEN = 32,
   parameter int ADDR_W  = 5,
   parameter int MIN_LAT = 2,
   parameter int NUM_BLK = 16
) (
   input  logic           clk,
   input  logic           rst,
   cbfp0_seq_ctrl_if.slave bus
);
   localparam int                WAIT_W    = $clog2(MIN_LAT) + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLK_LEN - 1);
   localparam logic [3:0]        LAST_BLK  = 4'(NUM_BLK - 1);

   typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RUN} rd_state_t;

   rd_state_t         r_state, w_state_nx;
   logic [WAIT_W-1:0] r_wait_cnt, w_wait_nx;
   logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nx;
   logic [ADDR_W-1:0] r_wr_cnt;
   logic              r_wr_bank_cur;
   logic              r_rd_bank;
   logic [1:0]        r_bank_full;
   logic              w_accept, w_wr_last, w_rd_last;

   logic              r_mag_en, r_min_clr, r_wr_en, r_wr_bank;
   logic [ADDR_W-1:0] r_wr_addr;
   logic              r_shift_load, r_rd_en, r_dout_valid, r_frame_done, r_ovf;
   logic [3:0]        r_blk_idx;

   assign w_accept  = bus.i_din_valid & ~r_bank_full[r_wr_bank_cur];
   assign w_wr_last = w_accept & (r_wr_cnt == LAST_ADDR);
   assign w_rd_last = (r_state == RD_RUN) & (r_rd_addr == LAST_ADDR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_cnt      <= '0;
         r_wr_bank_cur <= 1'b0;
         r_mag_en      <= 1'b0;
         r_min_clr     <= 1'b0;
         r_wr_en       <= 1'b0;
         r_wr_bank     <= 1'b0;
         r_wr_addr     <= '0;
         r_ovf         <= 1'b0;
         r_bank_full   <= 2'b00;
      end else begin
         r_mag_en  <= w_accept;
         r_wr_en   <= w_accept;
         r_min_clr <= w_accept & (r_wr_cnt == '0);
         if (w_accept) begin
            r_wr_addr <= r_wr_cnt;
            r_wr_bank <= r_wr_bank_cur;
            r_wr_cnt  <= w_wr_last ? '0 : r_wr_cnt + 1'b1;
         end
         if (w_wr_last) begin
            r_wr_bank_cur              <= ~r_wr_bank_cur;
            r_bank_full[r_wr_bank_cur] <= 1'b1;
         end
         // Writer never targets a full bank, so this clear never collides with the set above.
         if (w_rd_last)
            r_bank_full[r_rd_bank] <= 1'b0;
         if (bus.i_din_valid & ~w_accept)
            r_ovf <= 1'b1;
      end
   end

   always_comb begin
      w_state_nx   = r_state;
      w_wait_nx    = r_wait_cnt;
      w_rd_addr_nx = '0;
      case (r_state)
         RD_IDLE: begin
            if (r_bank_full[r_rd_bank]) begin
               w_state_nx = RD_WAIT;
               w_wait_nx  = WAIT_W'(MIN_LAT - 1);
            end
         end
         RD_WAIT: begin
            if (r_wait_cnt == '0)
               w_state_nx = RD_RUN;
            else
               w_wait_nx = r_wait_cnt - 1'b1;
         end
         RD_RUN: begin
            if (w_rd_last)
               w_state_nx = RD_IDLE;
            else
               w_rd_addr_nx = r_rd_addr + 1'b1;
         end
         default: w_state_nx = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= RD_IDLE;
         r_wait_cnt   <= '0;
         r_rd_addr    <= '0;
         r_rd_bank    <= 1'b0;
         r_shift_load <= 1'b0;
         r_rd_en      <= 1'b0;
         r_dout_valid <= 1'b0;
         r_frame_done <= 1'b0;
         r_blk_idx    <= '0;
      end else begin
         r_state      <= w_state_nx;
         r_wait_cnt   <= w_wait_nx;
         r_rd_addr    <= w_rd_addr_nx;
         // Pulse lands on the last wait cycle so the shifter holds the result before the first read.
         r_shift_load <= (w_state_nx == RD_WAIT) & (w_wait_nx == '0);
         r_rd_en      <= (w_state_nx == RD_RUN);
         r_dout_valid <= r_rd_en;
         r_frame_done <= w_rd_last & (r_blk_idx == LAST_BLK);
         if (w_rd_last) begin
            r_rd_bank <= ~r_rd_bank;
            r_blk_idx <= (r_blk_idx == LAST_BLK) ? 4'd0 : r_blk_idx + 1'b1;
         end
      end
   end

   assign bus.o_mag_en     = r_mag_en;
   assign bus.o_min_clr    = r_min_clr;
   assign bus.o_wr_en      = r_wr_en;
   assign bus.o_wr_bank    = r_wr_bank;
   assign bus.o_wr_addr    = r_wr_addr;
   assign bus.o_shift_load = r_shift_load;
   assign bus.o_rd_en      = r_rd_en;
   assign bus.o_rd_bank    = r_rd_bank;
   assign bus.o_rd_addr    = r_rd_addr;
   assign bus.o_dout_valid = r_dout_valid;
   assign bus.o_blk_idx    = r_blk_idx;
   assign bus.o_frame_done = r_frame_done;
   assign bus.o_ovf        = r_ovf;
endmodule

// File: tb/tb_cbfp0_seq_ctrl.sv
// tb/tb_cbfp0_seq_ctrl.sv - Randomized and directed bench for cbfp0_seq_ctrl against a timeline model
`timescale 1ns/1ps
module tb_cbfp0_seq_ctrl;
   localparam int BLK_LEN = 32;
   localparam int ADDR_W  = 5;
   localparam int MIN_LAT = 2;
   localparam int NUM_BLK = 16;
   localparam int HMAX    = 16384;
   localparam int NSIG    = 13;
   localparam int S_MAG = 0, S_WREN = 1, S_MINCLR = 2, S_WRADDR = 3, S_WRBANK = 4, S_SHIFT = 5;
   localparam int S_RDEN = 6, S_RDBANK = 7, S_RDADDR = 8, S_DV = 9, S_BLK = 10, S_FD = 11, S_OVF = 12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   hist [NSIG][HMAX];

   cbfp0_seq_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   cbfp0_seq_ctrl #(
      .BLK_LEN(BLK_LEN), .ADDR_W(ADDR_W), .MIN_LAT(MIN_LAT), .NUM_BLK(NUM_BLK)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      n_assert++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
      end
   endtask

   function automatic int cnt(input int s, input int a, input int b);
      int n = 0;
      for (int c = a; c <= b; c++)
         if (hist[s][c] != 0) n++;
      return n;
   endfunction

   function automatic int first_hi(input int s, input int a, input int b);
      for (int c = a; c <= b; c++)
         if (hist[s][c] != 0) return c;
      return -1;
   endfunction

   // Model: write side counts beats per bank; read side is a timeline p = cycles since leaving idle.
   bit m_full [2];
   int m_wbank, m_wcnt, m_rbank, m_p, m_blk;
   int e_wr_en, e_min_clr, e_wr_addr, e_wr_bank, e_shift, e_rd_en, e_rd_addr, e_dv, e_fd, e_ovf;

   initial begin
      bit din, acc, rd_last, idle_go;
      forever begin
         @(posedge clk);
         din = bus.i_din_valid;
         cyc++;
         if (rst) begin
            m_full[0] = 0; m_full[1] = 0;
            m_wbank = 0; m_wcnt = 0; m_rbank = 0; m_p = -1; m_blk = 0;
            e_wr_en = 0; e_min_clr = 0; e_wr_addr = 0; e_wr_bank = 0; e_shift = 0;
            e_rd_en = 0; e_rd_addr = 0; e_dv = 0; e_fd = 0; e_ovf = 0;
         end else begin
            acc     = din && !m_full[m_wbank];
            rd_last = (m_p == MIN_LAT + BLK_LEN - 1);
            idle_go = (m_p < 0) && m_full[m_rbank];
            e_dv      = e_rd_en;
            e_fd      = (rd_last && m_blk == NUM_BLK - 1) ? 1 : 0;
            e_wr_en   = acc ? 1 : 0;
            e_min_clr = (acc && m_wcnt == 0) ? 1 : 0;
            if (acc) begin
               e_wr_addr = m_wcnt;
               e_wr_bank = m_wbank;
            end
            if (din && !acc) e_ovf = 1;
            if (rd_last) begin
               m_full[m_rbank] = 0;
               m_rbank = 1 - m_rbank;
               m_blk = (m_blk + 1) % NUM_BLK;
               m_p = -1;
            end else if (idle_go) m_p = 0;
            else if (m_p >= 0) m_p++;
            if (acc) begin
               m_wcnt++;
               if (m_wcnt == BLK_LEN) begin
                  m_wcnt = 0;
                  m_full[m_wbank] = 1;
                  m_wbank = 1 - m_wbank;
               end
            end
            e_shift   = (m_p == MIN_LAT - 1) ? 1 : 0;
            e_rd_en   = (m_p >= MIN_LAT) ? 1 : 0;
            e_rd_addr = (m_p >= MIN_LAT) ? m_p - MIN_LAT : 0;
         end
         #1;
         if (cyc < HMAX) begin
            hist[S_MAG][cyc]    = int'(bus.o_mag_en);
            hist[S_WREN][cyc]   = int'(bus.o_wr_en);
            hist[S_MINCLR][cyc] = int'(bus.o_min_clr);
            hist[S_WRADDR][cyc] = int'(bus.o_wr_addr);
            hist[S_WRBANK][cyc] = int'(bus.o_wr_bank);
            hist[S_SHIFT][cyc]  = int'(bus.o_shift_load);
            hist[S_RDEN][cyc]   = int'(bus.o_rd_en);
            hist[S_RDBANK][cyc] = int'(bus.o_rd_bank);
            hist[S_RDADDR][cyc] = int'(bus.o_rd_addr);
            hist[S_DV][cyc]     = int'(bus.o_dout_valid);
            hist[S_BLK][cyc]    = int'(bus.o_blk_idx);
            hist[S_FD][cyc]     = int'(bus.o_frame_done);
            hist[S_OVF][cyc]    = int'(bus.o_ovf);
         end
         chk("mag_en",     int'(bus.o_mag_en),     e_wr_en);
         chk("wr_en",      int'(bus.o_wr_en),      e_wr_en);
         chk("min_clr",    int'(bus.o_min_clr),    e_min_clr);
         if (e_wr_en != 0) begin
            chk("wr_addr", int'(bus.o_wr_addr), e_wr_addr);
            chk("wr_bank", int'(bus.o_wr_bank), e_wr_bank);
         end
         chk("shift_load", int'(bus.o_shift_load), e_shift);
         chk("rd_en",      int'(bus.o_rd_en),      e_rd_en);
         if (e_rd_en != 0) chk("rd_addr", int'(bus.o_rd_addr), e_rd_addr);
         chk("rd_bank",    int'(bus.o_rd_bank),    m_rbank);
         chk("dout_valid", int'(bus.o_dout_valid), e_dv);
         chk("blk_idx",    int'(bus.o_blk_idx),    m_blk);
         chk("frame_done", int'(bus.o_frame_done), e_fd);
         chk("ovf",        int'(bus.o_ovf),        e_ovf);
      end
   end

   task automatic step(input bit v);
      @(negedge clk);
      bus.i_din_valid = v;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.i_din_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int t, f, errs, gap, pct, outs;
      bus.i_din_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Single block, continuous beats.
      step(1); t = cyc;
      repeat (31) step(1);
      repeat (80) step(0);
      errs = 0;
      for (int k = 0; k < 32; k++)
         if (hist[S_WREN][t+1+k] != 1 || hist[S_WRADDR][t+1+k] != k || hist[S_WRBANK][t+1+k] != 0) errs++;
      chk("t1_wr_seq_errs", errs, 0);
      chk("t1_min_clr_count", cnt(S_MINCLR, t, t + 100), 1);
      chk("t1_min_clr_first", hist[S_MINCLR][t+1], 1);
      chk("t1_shift_at_lat", hist[S_SHIFT][t+34], 1);
      chk("t1_shift_early", hist[S_SHIFT][t+33], 0);
      chk("t1_rd_first", first_hi(S_RDEN, t, t + 100), t + 35);
      chk("t1_rd_count", cnt(S_RDEN, t + 35, t + 66), 32);
      chk("t1_rd_after", hist[S_RDEN][t+67], 0);
      chk("t1_dv_first", first_hi(S_DV, t, t + 100), t + 36);
      chk("t1_dv_count", cnt(S_DV, t, t + 100), 32);

      // Full frame, 3 idle cycles between blocks (wider gaps from block 2 on).
      do_reset();
      for (int b = 0; b < NUM_BLK; b++) begin
         for (int i = 0; i < BLK_LEN; i++) begin
            step(1);
            if (b == 0 && i == 0) t = cyc;
         end
         gap = (b < 2) ? 3 : 3 + $urandom_range(0, 2);
         repeat (gap) step(0);
      end
      repeat (80) step(0);
      chk("t6_rd_last_blk0", hist[S_RDADDR][t+66], 31);
      chk("t6_wr_last_blk1", hist[S_WRADDR][t+67], 31);
      chk("t6_rd_bank_next", hist[S_RDBANK][t+67], 1);
      chk("t6_shift_bank1", hist[S_SHIFT][t+69], 1);
      chk("t6_rd_bank1_start", hist[S_RDEN][t+70] * 2 + hist[S_RDBANK][t+70], 3);
      chk("t2_dv_count", cnt(S_DV, t, cyc), NUM_BLK * BLK_LEN);
      chk("t2_fd_count", cnt(S_FD, t, cyc), 1);
      f = t;
      for (int c = t; c <= cyc; c++) if (hist[S_DV][c] != 0) f = c;
      chk("t2_fd_on_last_dv", hist[S_FD][f], 1);
      chk("t2_ovf", hist[S_OVF][cyc], 0);
      chk("t2_blk_wrap", hist[S_BLK][cyc], 0);

      // Sparse input: one beat every third cycle.
      do_reset();
      step(1); t = cyc; step(0); step(0);
      for (int i = 1; i < BLK_LEN; i++) begin
         step(1); step(0); step(0);
      end
      repeat (60) step(0);
      chk("t3_mag_count", cnt(S_MAG, t, cyc), 32);
      errs = 0; f = 0;
      for (int c = t; c <= cyc; c++)
         if (hist[S_WREN][c] != 0) begin
            if (hist[S_WRADDR][c] != f) errs++;
            f++;
         end
      chk("t3_wr_addr_errs", errs, 0);
      chk("t3_shift", hist[S_SHIFT][t+96], 1);
      f = first_hi(S_RDEN, t, cyc);
      chk("t3_rd_first", f, t + 97);
      chk("t3_rd_contig", cnt(S_RDEN, f, f + 31), 32);

      // Continuous input: both banks fill and beat 65 is dropped.
      do_reset();
      step(1); t = cyc;
      repeat (99) step(1);
      repeat (100) step(0);
      chk("t4_last_wr_addr", hist[S_WRADDR][t+64], 31);
      chk("t4_last_wr_bank", hist[S_WRBANK][t+64], 1);
      chk("t4_ovf_before", hist[S_OVF][t+64], 0);
      chk("t4_ovf_set", hist[S_OVF][t+65], 1);
      chk("t4_no_wr_drop", hist[S_WREN][t+65] + hist[S_WREN][t+67], 0);
      chk("t4_wr_resume", hist[S_WREN][t+68], 1);
      chk("t4_resume_addr", hist[S_WRADDR][t+68] + hist[S_WRBANK][t+68], 0);
      chk("t4_resume_clr", hist[S_MINCLR][t+68], 1);
      chk("t4_ovf_sticky", hist[S_OVF][cyc], 1);

      // Reset at beat 10 of block 2.
      do_reset();
      for (int b = 0; b < 2; b++) begin
         repeat (BLK_LEN) step(1);
         repeat (3) step(0);
      end
      repeat (10) step(1);
      @(negedge clk);
      rst = 1'b1;
      bus.i_din_valid = 1'b0;
      #1;
      outs = int'(bus.o_mag_en) + int'(bus.o_min_clr) + int'(bus.o_wr_en) + int'(bus.o_wr_bank)
           + int'(bus.o_wr_addr) + int'(bus.o_shift_load) + int'(bus.o_rd_en) + int'(bus.o_rd_bank)
           + int'(bus.o_rd_addr) + int'(bus.o_dout_valid) + int'(bus.o_blk_idx)
           + int'(bus.o_frame_done) + int'(bus.o_ovf);
      chk("t5_async_clear", outs, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      step(1); t = cyc;
      step(0); step(0);
      chk("t5_first_wr", hist[S_WREN][t+1] + hist[S_MINCLR][t+1], 2);
      chk("t5_first_addr_bank", hist[S_WRADDR][t+1] + hist[S_WRBANK][t+1] + hist[S_BLK][t+1], 0);

      // Random density segments, checked every cycle by the model.
      do_reset();
      for (int s = 0; s < 20; s++) begin
         pct = $urandom_range(20, 100);
         repeat (100) step($urandom_range(0, 99) < pct);
      end
      repeat (120) step(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
